// File: rtl/ws2801_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2801_pkg
// Description : Shared state encoding, default timing and pixel-width helper
//               for the WS2801 strip driver.
// Revision    : 1.0  initial release
// ============================================================================
package ws2801_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        LATCH = 3'd4
    } state_t;

    localparam int c_NUM_LEDS      = 5;
    localparam int c_CHANNELS      = 3;
    localparam int c_BITS_PER_CHAN = 8;
    localparam int c_CLK_DIV       = 4;
    localparam int c_LATCH_CYCLES  = 25000;

    function automatic int pix_w(input int channels, input int bits);
        return channels * bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2801_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : ws2801_phase_timer
// Description : Loadable down-counter; o_expired marks the last cycle of a
//               COUNT-cycle led_ck phase started by i_load.
// Revision    : 1.0  initial release
// ============================================================================
module ws2801_phase_timer #(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(COUNT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= c_CNT_W'(COUNT - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) r_active <= 1'b0;
            else             r_cnt    <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_expired = r_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ws2801_strip_driver.sv
`default_nettype none
// ============================================================================
// Module      : ws2801_strip_driver
// Description : Streams NUM_LEDS pixels MSB first on led_ck/led_sd, then
//               holds the line low for the strip latch gap.
// Revision    : 1.0  initial release
// ============================================================================
module ws2801_strip_driver
    import ws2801_pkg::*;
#(
    parameter int NUM_LEDS      = c_NUM_LEDS,
    parameter int CHANNELS      = c_CHANNELS,
    parameter int BITS_PER_CHAN = c_BITS_PER_CHAN,
    parameter int CLK_DIV       = c_CLK_DIV,
    parameter int LATCH_CYCLES  = c_LATCH_CYCLES,
    localparam int PIX_W        = pix_w(CHANNELS, BITS_PER_CHAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             err_underrun,
    output logic             led_ck,
    output logic             led_sd
);

    localparam int c_BIT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int c_PIX_W = $clog2(NUM_LEDS + 1);
    localparam int c_GAP_W = $clog2(LATCH_CYCLES + 1);

    state_t             r_state, w_state_n;
    logic [c_BIT_W-1:0] r_bit_cnt, w_bit_n;
    logic [c_PIX_W-1:0] r_pix_cnt, w_pix_n;
    logic [c_GAP_W-1:0] r_gap_cnt, w_gap_n;
    logic [PIX_W-1:0]   r_shift, w_shift_n;
    logic               r_led_sd, w_sd_n;
    logic               r_busy, r_pix_ready, r_frame_done, r_err, r_led_ck;
    logic               w_done_n, w_err_n, w_phase_load, w_expired;

    ws2801_phase_timer #(.COUNT(CLK_DIV)) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_phase_load),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_led_sd     <= 1'b0;
            r_led_ck     <= 1'b0;
            r_busy       <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_bit_cnt    <= w_bit_n;
            r_pix_cnt    <= w_pix_n;
            r_gap_cnt    <= w_gap_n;
            r_shift      <= w_shift_n;
            r_led_sd     <= w_sd_n;
            r_led_ck     <= (w_state_n == HIGH);
            r_busy       <= (w_state_n != IDLE);
            r_pix_ready  <= (w_state_n == LOAD);
            r_frame_done <= w_done_n;
            r_err        <= w_err_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_bit_n      = r_bit_cnt;
        w_pix_n      = r_pix_cnt;
        w_gap_n      = r_gap_cnt;
        w_shift_n    = r_shift;
        w_sd_n       = r_led_sd;
        w_done_n     = 1'b0;
        w_err_n      = 1'b0;
        w_phase_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_sd_n  = 1'b0;
                w_bit_n = '0;
                w_pix_n = '0;
                w_gap_n = '0;
                if (start) w_state_n = LOAD;
            end
            LOAD: begin
                if (pix_valid) begin
                    w_shift_n    = pix_data;
                    w_sd_n       = pix_data[PIX_W-1];
                    w_bit_n      = '0;
                    w_gap_n      = '0;
                    w_pix_n      = r_pix_cnt + c_PIX_W'(1);
                    w_phase_load = 1'b1;
                    w_state_n    = LOW;
                end else if (r_gap_cnt == c_GAP_W'(LATCH_CYCLES - 1)) begin
                    // The strip has already timed out and latched; park in
                    // LATCH on its final count so frame_done follows at once.
                    w_err_n   = 1'b1;
                    w_sd_n    = 1'b0;
                    w_state_n = LATCH;
                end else begin
                    w_gap_n = r_gap_cnt + c_GAP_W'(1);
                end
            end
            LOW: begin
                if (w_expired) begin
                    w_phase_load = 1'b1;
                    w_state_n    = HIGH;
                end
            end
            HIGH: begin
                if (w_expired) begin
                    if (r_bit_cnt != c_BIT_W'(PIX_W - 1)) begin
                        w_bit_n      = r_bit_cnt + c_BIT_W'(1);
                        w_shift_n    = r_shift << 1;
                        w_sd_n       = w_shift_n[PIX_W-1];
                        w_phase_load = 1'b1;
                        w_state_n    = LOW;
                    end else if (r_pix_cnt != c_PIX_W'(NUM_LEDS)) begin
                        w_state_n = LOAD;
                    end else begin
                        w_gap_n   = '0;
                        w_sd_n    = 1'b0;
                        w_state_n = LATCH;
                    end
                end
            end
            LATCH: begin
                w_sd_n = 1'b0;
                if (r_gap_cnt == c_GAP_W'(LATCH_CYCLES - 1)) begin
                    w_done_n  = 1'b1;
                    w_gap_n   = '0;
                    w_state_n = IDLE;
                end else begin
                    w_gap_n = r_gap_cnt + c_GAP_W'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign pix_ready    = r_pix_ready;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err_underrun = r_err;
    assign led_ck       = r_led_ck;
    assign led_sd       = r_led_sd;

endmodule
`default_nettype wire

// File: tb/tb_ws2801_strip_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2801_strip_driver
// Description : Scoreboard bench: expected pixels queued by the driver and
//               compared by a led_ck monitor; second instance free-runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ws2801_strip_driver;

    localparam int c_CLK_DIV = 2;
    localparam int c_LATCH   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1, rst_b = 1'b1;
    logic        start_a = 1'b0, valid_a = 1'b0, start_b = 1'b0, valid_b = 1'b0;
    logic [23:0] data_a = 24'h0;
    logic [23:0] data_b = 24'hC3A50F;
    logic        rdy_a, busy_a, done_a, err_a, ck_a, sd_a;
    logic        rdy_b, busy_b, done_b, err_b, ck_b, sd_b;

    always #5 clk = ~clk;

    ws2801_strip_driver #(
        .NUM_LEDS(2), .CHANNELS(3), .BITS_PER_CHAN(8),
        .CLK_DIV(c_CLK_DIV), .LATCH_CYCLES(c_LATCH)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pix_data(data_a), .pix_valid(valid_a),
        .pix_ready(rdy_a), .busy(busy_a), .frame_done(done_a), .err_underrun(err_a),
        .led_ck(ck_a), .led_sd(sd_a)
    );

    ws2801_strip_driver #(
        .NUM_LEDS(2), .CHANNELS(4), .BITS_PER_CHAN(6),
        .CLK_DIV(c_CLK_DIV), .LATCH_CYCLES(c_LATCH)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .pix_data(data_b), .pix_valid(valid_b),
        .pix_ready(rdy_b), .busy(busy_b), .frame_done(done_b), .err_underrun(err_b),
        .led_ck(ck_b), .led_sd(sd_b)
    );

    int total = 0;
    int bad   = 0;
    logic [23:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor for dut_a: reassembles pixels from led_ck rises, checks timing.
    int rises = 0, done_cnt = 0, err_cnt = 0, cyc = 0, err_cyc = 0, done_cyc = 0;
    int gap_low = 0, latch_low = 0, nbits = 0, hi_run = 0, low_run = 0;
    logic prev_ck = 1'b0, prev_sd = 1'b0, prev_done = 1'b0;
    logic [23:0] sh = 24'h0, exp_px;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            nbits = 0; hi_run = 0; low_run = 0;
            prev_ck = 1'b0; prev_sd = 1'b0; prev_done = 1'b0;
        end else begin
            if (done_a) begin
                done_cnt++;
                done_cyc  = cyc;
                latch_low = low_run;
                check("done_busy_low", {31'b0, busy_a}, 32'd0);
                check("done_single_pulse", {31'b0, prev_done}, 32'd0);
            end
            if (err_a) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (ck_a && !prev_ck) begin
                if (nbits != 0) check("ck_low_width", low_run, c_CLK_DIV);
                else            gap_low = low_run;
                rises++;
                sh = {sh[22:0], sd_a};
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    if (q.size() == 0) fail("unexpected_pixel");
                    else begin
                        exp_px = q.pop_front();
                        check("pixel_bits", {8'h0, sh}, {8'h0, exp_px});
                    end
                end
            end
            if (ck_a && prev_ck)  check("sd_stable_while_high", {31'b0, sd_a}, {31'b0, prev_sd});
            if (!ck_a && prev_ck) check("ck_high_width", hi_run, c_CLK_DIV);
            if (ck_a) begin hi_run++; low_run = 0; end
            else      begin low_run++; hi_run = 0; end
            prev_ck   = ck_a;
            prev_sd   = sd_a;
            prev_done = done_a;
        end
    end

    // Monitor for dut_b: start held high, pixels always valid.
    int nb = 0, rb = 0, done_b_cnt = 0;
    logic pck_b = 1'b0, after_b = 1'b0;
    logic [23:0] shb = 24'h0;

    always @(posedge clk) begin
        #1;
        if (rst_b) begin
            nb = 0; rb = 0; pck_b = 1'b0; after_b = 1'b0;
        end else begin
            if (after_b) begin
                check("b_ready_after_done", {31'b0, rdy_b}, 32'd1);
                after_b = 1'b0;
            end
            if (done_b) begin
                done_b_cnt++;
                check("b_rises_per_frame", rb, 48);
                check("b_idle_at_done", {30'b0, busy_b, rdy_b}, 32'd0);
                rb = 0;
                after_b = 1'b1;
            end
            if (ck_b && !pck_b) begin
                rb++;
                shb = {shb[22:0], sd_b};
                nb++;
                if (nb == 24) begin
                    nb = 0;
                    check("b_pixel_bits", {8'h0, shb}, 32'hC3A50F);
                end
            end
            if (err_b) check("b_no_underrun", 32'd1, 32'd0);
            pck_b = ck_b;
        end
    end

    task automatic send_pixel(input logic [23:0] px, input int stall, input bit expect_xfer);
        int n = 0;
        while (!rdy_a && n < 300) begin @(negedge clk); n++; end
        if (!rdy_a) fail("ready_timeout");
        repeat (stall) @(negedge clk);
        if (expect_xfer) q.push_back(px);
        data_a  = px;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic run_frame(input logic [23:0] p1, input logic [23:0] p2, input int stall2,
                             input bit abort, input bit poke, input string tag);
        int r0 = rises, d0 = done_cnt, e0 = err_cnt, n = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        send_pixel(p1, 0, 1'b1);
        if (poke) begin
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        send_pixel(p2, stall2, !abort);
        while (done_cnt == d0 && n < 400) begin @(negedge clk); n++; end
        if (done_cnt == d0) fail({tag, "_done_timeout"});
        check({tag, "_rises"}, rises - r0, abort ? 24 : 48);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_err_count"}, err_cnt - e0, abort ? 1 : 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {26'b0, rdy_a, busy_a, done_a, err_a, ck_a, sd_a}, 32'd0);
    endtask

    initial begin
        int n;
        int r0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        check("reset_b_outputs", {26'b0, rdy_b, busy_b, done_b, err_b, ck_b, sd_b}, 32'd0);
        rst = 1'b0; rst_b = 1'b0;
        start_b = 1'b1; valid_b = 1'b1;

        run_frame(24'hFF0000, 24'h00FF00, 0, 1'b0, 1'b0, "b2b");
        check("b2b_interpixel_low", gap_low, c_CLK_DIV + 1);
        check("b2b_latch_low", latch_low, c_LATCH);

        run_frame(24'hA53C96, 24'h0F1E2D, 5, 1'b0, 1'b0, "stall5");
        check("stall5_interpixel_low", gap_low, c_CLK_DIV + 1 + 5);

        run_frame(24'h123456, 24'hABCDEF, c_LATCH, 1'b1, 1'b0, "stall20");
        check("stall20_err_to_done", done_cyc - err_cyc, 1);
        check("stall20_queue_empty", q.size(), 0);
        @(negedge clk);
        check("stall20_idle", {30'b0, busy_a, rdy_a}, 32'd0);

        run_frame(24'h800001, 24'h7FFFFE, 0, 1'b0, 1'b1, "poke");
        repeat (6) @(negedge clk);
        check("poke_no_restart", {30'b0, busy_a, rdy_a}, 32'd0);

        // Mid-frame reset after ten bits of the first pixel.
        r0 = rises;
        n  = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        send_pixel(24'hC0FFEE, 0, 1'b1);
        while (rises - r0 < 10 && n < 300) begin @(negedge clk); n++; end
        if (rises - r0 < 10) fail("rst_bit_wait");
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midframe_reset_outputs");
        q.delete();
        rst = 1'b0;
        run_frame(24'h135790, 24'h2468AC, 0, 1'b0, 1'b0, "after_rst");

        check("b_frames_repeat", {31'b0, done_b_cnt >= 2}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
